// File: rtl/store_pkg.sv
// Shared definitions for the store/unload tank: operating mode and default sizing.
package store_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } mode_e;

    localparam int DEFAULT_N     = 25000;
    localparam int DEFAULT_CBITS = 15;

endpackage

// File: rtl/store_unload.sv
// Unit-counting tank: fills one unit per accepted input until it holds N units,
// then drains one unit per accepted output until empty, and repeats.
module store_unload
    import store_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int CBITS = DEFAULT_CBITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CBITS-1:0] level,
    output logic             drain,
    output logic             full,
    output logic             empty
);

    // The level counter must be able to hold the full capacity.
    if (N < 1 || N >= (2 ** CBITS)) begin : g_bad_size
        $error("store_unload: N must satisfy 1 <= N < 2**CBITS");
    end

    localparam logic [CBITS-1:0] CAP = CBITS'(N);
    localparam logic [CBITS-1:0] ONE = CBITS'(1);

    mode_e            mode_q,  mode_d;
    logic [CBITS-1:0] level_q, level_d;
    logic             full_q,  full_d;
    logic             empty_q, empty_d;
    logic             overflow;

    // Handshake outputs depend only on mode, level and reset; the next-state
    // values below then follow from whichever single transfer happens.
    always_comb begin
        overflow  = (level_q > CAP);
        in_ready  = !rst && !overflow && (mode_q == FILL)  && (level_q < CAP);
        out_valid = !rst && !overflow && (mode_q == DRAIN) && (level_q != '0);
        level_d   = level_q;
        mode_d    = mode_q;
        if (overflow) begin
            level_d = CAP;
            mode_d  = DRAIN;
        end else if (in_valid && in_ready) begin
            level_d = level_q + ONE;
        end else if (out_valid && out_ready) begin
            level_d = level_q - ONE;
        end
        if (!overflow) begin
            if (level_d == CAP) begin
                mode_d = DRAIN;
            end else if (level_d == '0) begin
                mode_d = FILL;
            end
        end
        full_d  = (level_d == CAP);
        empty_d = (level_d == '0);
    end

    // Mode, level and status flags all advance together; reset discards any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= FILL;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            mode_q  <= mode_d;
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign level = level_q;
    assign drain = (mode_q == DRAIN);
    assign full  = full_q;
    assign empty = empty_q;

    a_level_bound : assert property (@(posedge clk) disable iff (rst) level_q <= CAP);
    a_exclusive   : assert property (@(posedge clk) !(in_ready && out_valid));
    a_drain_exit  : assert property (@(posedge clk) disable iff (rst) $fell(mode_q == DRAIN) |-> empty_q);
    a_fill_exit   : assert property (@(posedge clk) disable iff (rst) $rose(mode_q == DRAIN) |-> full_q);

endmodule
